seq_normalizer_32: RTL and testbench



---
 rtl/seq_normalizer_32_pkg.sv | 17 +
 rtl/seq_normalizer_32_norm_detect.sv | 21 ++
 rtl/seq_normalizer_32.sv | 100 ++++++++++
 tb/tb_seq_normalizer_32.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_normalizer_32_pkg.sv
// Shared definitions for the iterative normalizer and the neighbouring shifter stages.
package seq_normalizer_32_pkg;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  // Shift direction encoding consumed by the barrel shifter stages.
  localparam logic SH_DIR_LEFT  = 1'b0;
  localparam logic SH_DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/seq_normalizer_32_norm_detect.sv
// Combinational test of a work word: already normalized, or holding no normalizable bit.
module norm_detect
  import seq_normalizer_32_pkg::*;
(
  input  logic [WIDTH-1:0] word_i,
  input  logic             signedMode_i,
  output logic             isNorm_o,
  output logic             isZero_o
);

  logic allZero;
  logic allOne;

  assign allZero = (word_i == '0);
  assign allOne  = (word_i == '1);

  // In signed mode a word of pure sign bits (0 or -1) can never be normalized.
  assign isZero_o = signedMode_i ? (allZero || allOne) : allZero;
  assign isNorm_o = signedMode_i ? (word_i[WIDTH-1] ^ word_i[WIDTH-2]) : word_i[WIDTH-1];

endmodule

// File: rtl/seq_normalizer_32.sv
// Iterative left-normalizer: shifts one bit per clock and reports the shift count as SH_AMT.
module seq_normalizer_32
  import seq_normalizer_32_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED_MODE,
  input  logic [WIDTH-1:0] D_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D_OUT,
  output logic [AMT_W-1:0] SH_AMT,
  output logic             ZERO
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] dOut_q, dOut_d;
  logic [AMT_W-1:0] shAmt_q, shAmt_d;
  logic             zero_q, zero_d;
  logic             isNorm;
  logic             isZero;

  norm_detect uDetect (
    .word_i       (work_q),
    .signedMode_i (mode_q),
    .isNorm_o     (isNorm),
    .isZero_o     (isZero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      dOut_q  <= '0;
      shAmt_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      dOut_q  <= dOut_d;
      shAmt_q <= shAmt_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    mode_d  = mode_q;
    dOut_d  = dOut_q;
    shAmt_d = shAmt_q;
    zero_d  = zero_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (START) begin
          work_d  = D_IN;
          count_d = '0;
          mode_d  = SIGNED_MODE;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Zero is tested first; only an unshifted operand can reach it, so D_OUT is the operand.
        if (isZero) begin
          dOut_d  = work_q;
          shAmt_d = '0;
          zero_d  = 1'b1;
          state_d = ST_DONE;
        end else if (isNorm) begin
          dOut_d  = work_q;
          shAmt_d = count_q;
          zero_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          work_d  = {work_q[WIDTH-2:0], 1'b0};
          count_d = count_q + AMT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign BUSY   = (state_q == ST_SHIFT);
  assign DONE   = (state_q == ST_DONE);
  assign D_OUT  = dOut_q;
  assign SH_AMT = shAmt_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_seq_normalizer_32.sv
// Scoreboard bench for seq_normalizer_32: a driver queues expected results, a monitor checks them.
module tb_seq_normalizer_32;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        SIGNED_MODE;
  logic [31:0] D_IN;
  logic        BUSY;
  logic        DONE;
  logic [31:0] D_OUT;
  logic [4:0]  SH_AMT;
  logic        ZERO;

  typedef struct {
    logic [31:0] dout;
    logic [4:0]  amt;
    logic        zero;
    int          start;
    int          lat;
  } exp_t;

  exp_t        expQ[$];
  int          cycleCount;
  int          checksTotal;
  int          checksPassed;
  logic [31:0] lastDout;
  logic [4:0]  lastAmt;
  logic        lastZero;

  seq_normalizer_32 dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .SIGNED_MODE (SIGNED_MODE),
    .D_IN        (D_IN),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .D_OUT       (D_OUT),
    .SH_AMT      (SH_AMT),
    .ZERO        (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCount <= cycleCount + 1;

  // Reference: count leading zeros (unsigned) or redundant sign bits (signed).
  function automatic exp_t model(input logic [31:0] d, input logic s, input int startC);
    exp_t e;
    int   n;
    e.start = startC;
    if ((d == 32'h0) || (s && (d == 32'hFFFF_FFFF))) begin
      e.dout = d;
      e.amt  = 5'd0;
      e.zero = 1'b1;
      e.lat  = 2;
    end else begin
      n = 0;
      if (s) begin
        while (d[30-n] == d[31]) n++;
      end else begin
        while (d[31-n] == 1'b0) n++;
      end
      e.dout = d << n;
      e.amt  = 5'(n);
      e.zero = 1'b0;
      e.lat  = n + 2;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checksTotal++;
    if (act === expv) checksPassed++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cycleCount);
  endtask

  // Monitor: BUSY window, DONE timing and result, and output hold between completions.
  always @(negedge CLK) begin
    exp_t e;
    int   due;
    logic expBusy;
    if (!RST) begin
      expBusy = 1'b0;
      due     = 0;
      if (expQ.size() > 0) begin
        due = expQ[0].start + expQ[0].lat;
        if ((cycleCount > expQ[0].start) && (cycleCount < due)) expBusy = 1'b1;
      end
      checkOutput("busy", {31'b0, BUSY}, {31'b0, expBusy});
      if (DONE) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("done_cycle", cycleCount, due);
          checkOutput("d_out", D_OUT, e.dout);
          checkOutput("sh_amt", {27'b0, SH_AMT}, {27'b0, e.amt});
          checkOutput("zero", {31'b0, ZERO}, {31'b0, e.zero});
          lastDout = e.dout;
          lastAmt  = e.amt;
          lastZero = e.zero;
        end
      end else begin
        checkOutput("hold_d_out", D_OUT, lastDout);
        checkOutput("hold_sh_amt", {27'b0, SH_AMT}, {27'b0, lastAmt});
        checkOutput("hold_zero", {31'b0, ZERO}, {31'b0, lastZero});
        if ((expQ.size() > 0) && (cycleCount >= due)) begin
          checkOutput("missing_done", 32'd0, 32'd1);
          void'(expQ.pop_front());
        end
      end
    end
  end

  // Issues one START cycle; returns #1 after the edge that sampled it.
  task automatic applyStimulus(input logic [31:0] d, input logic s);
    START       = 1'b1;
    D_IN        = d;
    SIGNED_MODE = s;
    expQ.push_back(model(d, s, cycleCount));
    @(posedge CLK);
    #1;
    START       = 1'b0;
    D_IN        = $urandom;
    SIGNED_MODE = 1'($urandom);
  endtask

  task automatic waitDone();
    int k;
    for (k = 0; k < 60; k++) begin
      if (expQ.size() == 0) break;
      @(posedge CLK);
      #1;
    end
    if (expQ.size() != 0) begin
      checkOutput("timeout", 32'd1, 32'd0);
      expQ.delete();
    end
  endtask

  task automatic doReset();
    RST = 1'b1;
    expQ.delete();
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    lastDout = '0;
    lastAmt  = '0;
    lastZero = 1'b0;
  endtask

  logic [31:0] dirData[9] = '{32'h0000_0001, 32'h8000_0000, 32'h00F0_0000, 32'h0000_0000,
                              32'h0000_0001, 32'hFFFF_FFF0, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'h3FFF_FFFF};
  logic        dirMode[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    exp_t        e;
    logic [31:0] d;
    logic        s;
    cycleCount   = 0;
    checksTotal  = 0;
    checksPassed = 0;
    lastDout     = '0;
    lastAmt      = '0;
    lastZero     = 1'b0;
    RST          = 1'b1;
    START        = 1'b0;
    SIGNED_MODE  = 1'b0;
    D_IN         = 32'hDEAD_BEEF;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("reset_d_out", D_OUT, 32'h0);
    checkOutput("reset_flags", {27'b0, BUSY, DONE, ZERO, 2'b0}, 32'h0);
    checkOutput("reset_sh_amt", {27'b0, SH_AMT}, 32'h0);
    @(posedge CLK);
    #1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(dirData[i], dirMode[i]);
      waitDone();
      repeat (2) @(posedge CLK);
      #1;
    end

    // START with new data while busy must be ignored.
    applyStimulus(32'h0000_0100, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    START = 1'b1; D_IN = 32'h0000_0003; SIGNED_MODE = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    waitDone();

    // Back-to-back: second START lands in the DONE cycle of the first.
    applyStimulus(32'h0001_0000, 1'b0);
    e = model(32'h0001_0000, 1'b0, 0);
    repeat (e.lat - 1) @(posedge CLK);
    #1;
    applyStimulus(32'hFFFF_0000, 1'b1);
    waitDone();

    // Reset in cycle 10 of a 31-shift operation aborts it without a DONE.
    applyStimulus(32'h0000_0001, 1'b0);
    repeat (9) @(posedge CLK);
    #1;
    doReset();
    @(negedge CLK);
    checkOutput("abort_d_out", D_OUT, 32'h0);
    checkOutput("abort_flags", {27'b0, BUSY, DONE, ZERO, 2'b0}, 32'h0);
    checkOutput("abort_sh_amt", {27'b0, SH_AMT}, 32'h0);
    repeat (40) @(posedge CLK);
    #1;
    applyStimulus(32'h0000_0400, 1'b1);
    waitDone();

    for (int i = 0; i < 25; i++) begin
      d = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom);
      if (s && $urandom_range(0, 1) == 1) d = ~d;
      applyStimulus(d, s);
      if ($urandom_range(0, 3) == 0) begin
        e = model(d, s, 0);
        if (e.lat > 1) begin
          repeat (e.lat - 1) @(posedge CLK);
          #1;
        end
      end else begin
        waitDone();
      end
    end
    waitDone();
    repeat (3) @(posedge CLK);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
